// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution controller: evaluates an accepted control-flow instruction,
// reports the outcome one cycle later and drives a held redirect to fetch on mispredict.
`timescale 1ns/1ps
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_opr1,
  input  logic [31:0]      in_opr2,
  input  logic [2:0]       in_func3,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_misalign,
  output logic             res_illegal,
  output logic [31:0]      link_data,
  output logic             flush,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EVAL     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             in_ready_r;
  logic             res_valid_r;
  logic             res_taken_r;
  logic             res_mispredict_r;
  logic             res_misalign_r;
  logic             res_illegal_r;
  logic             flush_r;
  logic [31:0]      link_data_r;
  logic [31:0]      next_pc_r;
  logic             redirect_valid_r;
  logic [31:0]      redirect_pc_r;
  logic [CNT_W-1:0] cnt_r;

  logic        accept_s;
  logic        handshake_s;
  logic        enter_redirect_s;
  logic        is_cond_s;
  logic        cond_taken_s;
  logic        bad_func3_s;
  logic        illegal_s;
  logic        taken_s;
  logic [31:0] seq_pc_s;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;
  logic        misalign_s;
  logic        wrong_s;
  logic        mispredict_s;
  logic        ready_next_s;

  assign in_ready       = in_ready_r;
  assign res_valid      = res_valid_r;
  assign res_taken      = res_taken_r;
  assign res_mispredict = res_mispredict_r;
  assign res_misalign   = res_misalign_r;
  assign res_illegal    = res_illegal_r;
  assign flush          = flush_r;
  assign link_data      = link_data_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign mispredict_cnt = cnt_r;

  // Resolve the incoming instruction so results can be registered at acceptance.
  always_comb begin
    cond_taken_s = 1'b0;
    bad_func3_s  = 1'b0;
    case (in_func3)
      3'b000:  cond_taken_s = (in_opr1 == in_opr2);
      3'b001:  cond_taken_s = (in_opr1 != in_opr2);
      3'b100:  cond_taken_s = ($signed(in_opr1) <  $signed(in_opr2));
      3'b101:  cond_taken_s = ($signed(in_opr1) >= $signed(in_opr2));
      3'b110:  cond_taken_s = (in_opr1 <  in_opr2);
      3'b111:  cond_taken_s = (in_opr1 >= in_opr2);
      default: bad_func3_s  = 1'b1;
    endcase

    is_cond_s = ~(in_is_jal | in_is_jalr);
    illegal_s = is_cond_s & bad_func3_s;
    taken_s   = in_is_jal | in_is_jalr | (is_cond_s & cond_taken_s);
    seq_pc_s  = in_pc + 32'd4;

    if (in_is_jalr) begin
      target_s = (in_opr1 + in_imm) & 32'hFFFF_FFFE;
    end else begin
      target_s = in_pc + in_imm;
    end

    if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = seq_pc_s;
    end

    // Misaligned and illegal outcomes never redirect, so they mask the mispredict.
    misalign_s   = taken_s & target_s[1];
    wrong_s      = (taken_s != in_pred_taken) | (taken_s & (target_s != in_pred_target));
    mispredict_s = wrong_s & ~misalign_s & ~illegal_s;
  end

  // Next-state and handshake decode.
  always_comb begin
    accept_s         = in_valid & in_ready_r;
    handshake_s      = redirect_valid_r & redirect_ready;
    enter_redirect_s = (state_r == ST_EVAL) & res_mispredict_r;
    state_next_s     = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_EVAL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (res_mispredict_r) begin
          state_next_s = ST_REDIRECT;
        end else if (accept_s) begin
          state_next_s = ST_EVAL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (handshake_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REDIRECT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
    // EVAL is only entered through acceptance, so the new instruction decides readiness.
    ready_next_s = (state_next_s == ST_IDLE) | ((state_next_s == ST_EVAL) & ~mispredict_s);
  end

  // State and acceptance readiness registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= ready_next_s;
    end
  end

  // Resolution results, presented for exactly the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r      <= 1'b0;
      res_taken_r      <= 1'b0;
      res_mispredict_r <= 1'b0;
      res_misalign_r   <= 1'b0;
      res_illegal_r    <= 1'b0;
      flush_r          <= 1'b0;
      link_data_r      <= 32'd0;
      next_pc_r        <= 32'd0;
    end else if (accept_s) begin
      res_valid_r      <= 1'b1;
      res_taken_r      <= taken_s;
      res_mispredict_r <= mispredict_s;
      res_misalign_r   <= misalign_s;
      res_illegal_r    <= illegal_s;
      flush_r          <= mispredict_s;
      link_data_r      <= seq_pc_s;
      next_pc_r        <= next_pc_s;
    end else begin
      res_valid_r      <= 1'b0;
      res_taken_r      <= 1'b0;
      res_mispredict_r <= 1'b0;
      res_misalign_r   <= 1'b0;
      res_illegal_r    <= 1'b0;
      flush_r          <= 1'b0;
    end
  end

  // Redirect request held until fetch takes it; counter saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
      cnt_r            <= {CNT_W{1'b0}};
    end else if (enter_redirect_s) begin
      redirect_valid_r <= 1'b1;
      redirect_pc_r    <= next_pc_r;
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (handshake_s) begin
      redirect_valid_r <= 1'b0;
    end else begin
      redirect_valid_r <= redirect_valid_r;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_branch_resolve_ctrl;
  localparam int CW = 4;
  localparam logic [31:0] CNT_MAX = 32'd15;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [31:0] in_pc, in_imm, in_opr1, in_opr2;
  logic [2:0] in_func3;
  logic in_is_jal, in_is_jalr, in_pred_taken;
  logic [31:0] in_pred_target;
  logic res_valid, res_taken, res_mispredict, res_misalign, res_illegal;
  logic [31:0] link_data;
  logic flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [CW-1:0] mispredict_cnt;

  branch_resolve_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_opr1(in_opr1), .in_opr2(in_opr2),
    .in_func3(in_func3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_misalign(res_misalign), .res_illegal(res_illegal), .link_data(link_data),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  typedef struct packed {
    logic [31:0] pc, imm, opr1, opr2;
    logic [2:0]  f3;
    logic        jal, jalr, pt;
    logic [31:0] ptgt;
    logic        e_taken, e_misp, e_mis, e_ill;
    logic [31:0] e_npc;
  } vec_t;

  typedef struct packed {
    logic        taken, misp, misal, ill;
    logic [31:0] tgt, npc, link;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkvec(input logic [31:0] pc, imm, o1, o2, input logic [2:0] f3,
                                 input logic jal, jalr, pt, input logic [31:0] ptgt,
                                 input logic et, em, ema, ei, input logic [31:0] enpc);
    vec_t v;
    v = '{pc:pc, imm:imm, opr1:o1, opr2:o2, f3:f3, jal:jal, jalr:jalr, pt:pt, ptgt:ptgt,
          e_taken:et, e_misp:em, e_mis:ema, e_ill:ei, e_npc:enpc};
    return v;
  endfunction

  // Reference resolution from the instruction-set rules.
  function automatic res_t ref_resolve(input logic [31:0] pc, imm, o1, o2, input logic [2:0] f3,
                                       input logic jal, jalr, pt, input logic [31:0] ptgt);
    res_t r;
    bit branch;
    longint so1, so2;
    so1 = longint'($signed(o1));
    so2 = longint'($signed(o2));
    branch = !jal && !jalr;
    r.ill = branch && (f3 == 3'd2 || f3 == 3'd3);
    if (!branch) r.taken = 1'b1;
    else if (f3 == 3'd0) r.taken = (o1 == o2);
    else if (f3 == 3'd1) r.taken = (o1 != o2);
    else if (f3 == 3'd4) r.taken = (so1 < so2);
    else if (f3 == 3'd5) r.taken = (so1 >= so2);
    else if (f3 == 3'd6) r.taken = (longint'(o1) < longint'(o2));
    else if (f3 == 3'd7) r.taken = (longint'(o1) >= longint'(o2));
    else r.taken = 1'b0;
    if (jalr) r.tgt = 32'((longint'(o1) + longint'(imm)) % 64'h1_0000_0000) & 32'hFFFF_FFFE;
    else      r.tgt = 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000);
    r.link  = 32'((longint'(pc) + 64'd4) % 64'h1_0000_0000);
    r.npc   = r.taken ? r.tgt : r.link;
    r.misal = r.taken && r.tgt[1];
    r.misp  = !r.ill && !r.misal && ((r.taken != pt) || (r.taken && r.tgt != ptgt));
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_pc = v.pc; in_imm = v.imm; in_opr1 = v.opr1; in_opr2 = v.opr2; in_func3 = v.f3;
    in_is_jal = v.jal; in_is_jalr = v.jalr; in_pred_taken = v.pt; in_pred_target = v.ptgt;
  endtask

  // One instruction from IDLE through its result and, if needed, a one-cycle redirect.
  task automatic run_vec(input string name, input vec_t v);
    chk({name, ".ready_pre"}, in_ready, 1'b1);
    drive(v);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({name, ".res_valid"}, res_valid, 1'b1);
    chk({name, ".taken"}, res_taken, v.e_taken);
    chk({name, ".mispredict"}, res_mispredict, v.e_misp);
    chk({name, ".misalign"}, res_misalign, v.e_mis);
    chk({name, ".illegal"}, res_illegal, v.e_ill);
    chk({name, ".flush"}, flush, v.e_misp);
    if (v.jal || v.jalr) chk({name, ".link"}, link_data, v.pc + 32'd4);
    if (v.e_misp) begin
      chk({name, ".ready_eval"}, in_ready, 1'b0);
      redirect_ready = 1'b1;
      tick;
      if (exp_cnt < CNT_MAX) exp_cnt++;
      chk({name, ".redir_valid"}, redirect_valid, 1'b1);
      chk({name, ".redir_pc"}, redirect_pc, v.e_npc);
      chk({name, ".cnt"}, mispredict_cnt, exp_cnt);
      chk({name, ".res_gone"}, res_valid, 1'b0);
      tick;
      redirect_ready = 1'b0;
      chk({name, ".redir_done"}, redirect_valid, 1'b0);
      chk({name, ".ready_post"}, in_ready, 1'b1);
    end else begin
      chk({name, ".ready_eval"}, in_ready, 1'b1);
      chk({name, ".no_redir"}, redirect_valid, 1'b0);
      tick;
      chk({name, ".res_gone"}, res_valid, 1'b0);
    end
  endtask

  vec_t vecs[11];
  vec_t v;
  res_t m_res, tmp;
  logic m_ready, m_valid, m_redir, m_jmp, n_redir, acc;
  logic [31:0] m_rpc, m_cnt;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; redirect_ready = 1'b0;
    in_pc = 32'd0; in_imm = 32'd0; in_opr1 = 32'd0; in_opr2 = 32'd0; in_func3 = 3'd0;
    in_is_jal = 1'b0; in_is_jalr = 1'b0; in_pred_taken = 1'b0; in_pred_target = 32'd0;

    //          pc            imm           opr1          opr2    f3    jal  jalr pt   ptgt      tk   msp  mis  ill  npc
    vecs[0]  = mkvec(32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h120);
    vecs[1]  = mkvec(32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
    vecs[2]  = mkvec(32'h40, 32'h0, 32'h205, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'h204);
    vecs[3]  = mkvec(32'h40, 32'h0, 32'h203, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h202);
    vecs[4]  = mkvec(32'h10, 32'h6, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h16);
    vecs[5]  = mkvec(32'h80, 32'h8, 32'h5, 32'h5, 3'b010, 1'b0, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b1, 32'h84);
    vecs[6]  = mkvec(32'h200, 32'hFFFF_FFF0, 32'h9, 32'h9, 3'b000, 1'b0, 1'b0, 1'b1, 32'h1F0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1F0);
    vecs[7]  = mkvec(32'h300, 32'h100, 32'h8000_0000, 32'h0, 3'b101, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 32'h304);
    vecs[8]  = mkvec(32'h300, 32'h100, 32'h8000_0000, 32'h0, 3'b111, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
    vecs[9]  = mkvec(32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
    vecs[10] = mkvec(32'h500, 32'h40, 32'h7, 32'h7, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h504);

    tick; tick;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.res_valid", res_valid, 1'b0);
    chk("rst.flags", {res_taken, res_mispredict, res_misalign, res_illegal, flush}, 5'd0);
    chk("rst.redir_valid", redirect_valid, 1'b0);
    chk("rst.redir_pc", redirect_pc, 32'd0);
    chk("rst.link", link_data, 32'd0);
    chk("rst.cnt", mispredict_cnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick;
    chk("idle.res_valid", res_valid, 1'b0);

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Four back-to-back correct predictions at full rate.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = mkvec(32'h1000 + 32'(i * 4), 32'h40, 32'h3, (i % 2 == 0) ? 32'h3 : 32'h4,
                (i % 2 == 0) ? 3'b000 : 3'b001, 1'b0, 1'b0, 1'b1, 32'h1040 + 32'(i * 4),
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(v);
      tick;
      chk($sformatf("b2b%0d.res_valid", i), res_valid, 1'b1);
      chk($sformatf("b2b%0d.mispredict", i), res_mispredict, 1'b0);
      chk($sformatf("b2b%0d.in_ready", i), in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick;
    chk("b2b.end", res_valid, 1'b0);

    // Redirect held back by fetch for three cycles while decode keeps offering.
    drive(vecs[2]);
    in_valid = 1'b1;
    tick;
    chk("hold.misp", res_mispredict, 1'b1);
    chk("hold.link", link_data, 32'h44);
    tick;
    if (exp_cnt < CNT_MAX) exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d.redir_valid", i), redirect_valid, 1'b1);
      chk($sformatf("hold%0d.redir_pc", i), redirect_pc, 32'h204);
      chk($sformatf("hold%0d.in_ready", i), in_ready, 1'b0);
      chk($sformatf("hold%0d.res_valid", i), res_valid, 1'b0);
      tick;
    end
    in_valid = 1'b0;
    redirect_ready = 1'b1;
    tick;
    redirect_ready = 1'b0;
    chk("hold.released", redirect_valid, 1'b0);
    chk("hold.in_ready", in_ready, 1'b1);
    chk("hold.no_accept", res_valid, 1'b0);
    chk("hold.cnt", mispredict_cnt, exp_cnt);

    // Drive the 4-bit counter into saturation.
    v = mkvec(32'h600, 32'h10, 32'h1, 32'h2, 3'b000, 1'b0, 1'b0, 1'b1, 32'h610,
              1'b0, 1'b1, 1'b0, 1'b0, 32'h604);
    for (int k = 0; k < 13; k++) run_vec($sformatf("sat%0d", k), v);
    chk("sat.final", mispredict_cnt, 32'd15);

    // Asynchronous reset while a redirect is pending.
    drive(v);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk("arst.pre_redir", redirect_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.redir_valid", redirect_valid, 1'b0);
    chk("arst.cnt", mispredict_cnt, 32'd0);
    chk("arst.redir_pc", redirect_pc, 32'd0);
    chk("arst.in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    tick;
    chk("arst.post_ready", in_ready, 1'b1);
    chk("arst.post_redir", redirect_valid, 1'b0);
    chk("arst.post_res", res_valid, 1'b0);

    // Randomized traffic against the reference model.
    m_ready = 1'b1; m_valid = 1'b0; m_redir = 1'b0; m_jmp = 1'b0;
    m_rpc = 32'd0; m_cnt = 32'd0; m_res = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.in_ready", in_ready, m_ready);
      chk("rnd.res_valid", res_valid, m_valid);
      chk("rnd.flush", flush, m_valid && m_res.misp);
      chk("rnd.redir_valid", redirect_valid, m_redir);
      chk("rnd.cnt", mispredict_cnt, m_cnt);
      if (m_valid) begin
        chk("rnd.flags", {res_taken, res_mispredict, res_misalign, res_illegal},
            {m_res.taken, m_res.misp, m_res.misal, m_res.ill});
        if (m_jmp) chk("rnd.link", link_data, m_res.link);
      end
      if (m_redir) chk("rnd.redir_pc", redirect_pc, m_rpc);

      in_valid = ($urandom_range(0, 3) != 0);
      redirect_ready = 1'($urandom_range(0, 1));
      in_func3 = 3'($urandom_range(0, 7));
      c = c;
      in_is_jal = 1'b0; in_is_jalr = 1'b0;
      case ($urandom_range(0, 9))
        0: in_is_jal = 1'b1;
        1: in_is_jalr = 1'b1;
        default: ;
      endcase
      in_pc = $urandom & 32'hFFFF_FFFC;
      in_imm = $urandom & 32'h0000_0FFE;
      if ($urandom_range(0, 1) == 1) in_imm = in_imm | 32'hFFFF_F000;
      in_opr1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      in_opr2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) in_opr2 = 32'hFFFF_FFFF - in_opr2;
      in_pred_taken = 1'($urandom_range(0, 1));
      tmp = ref_resolve(in_pc, in_imm, in_opr1, in_opr2, in_func3, in_is_jal, in_is_jalr, 1'b0, 32'h0);
      in_pred_target = ($urandom_range(0, 2) != 0) ? tmp.tgt : $urandom;

      acc = in_valid && m_ready;
      n_redir = m_redir ? !redirect_ready : (m_valid && m_res.misp);
      if (!m_redir && m_valid && m_res.misp) begin
        m_rpc = m_res.npc;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_redir = n_redir;
      m_valid = acc;
      if (acc) begin
        m_res = ref_resolve(in_pc, in_imm, in_opr1, in_opr2, in_func3, in_is_jal, in_is_jalr,
                            in_pred_taken, in_pred_target);
        m_jmp = in_is_jal || in_is_jalr;
      end
      m_ready = !m_redir && !(m_valid && m_res.misp);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
